// File: rtl/mix_columns_pipe.sv
// AES MixColumns / InvMixColumns engine with valid/ready handshake.
// Transforms COLS_PER_CYCLE columns per BUSY cycle through a registered mixer.
module mix_columns_pipe #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int N  = 4 / COLS_PER_CYCLE;
  localparam int GW = 32 * COLS_PER_CYCLE;

  generate
    if (!(COLS_PER_CYCLE == 1 ||
          COLS_PER_CYCLE == 2 ||
          COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [127:0]    in_q;
  logic            inv_q;
  logic [127:0]    out_q;
  logic [127:0]    out_d;
  logic [2:0]      k_q;
  logic [1:0]      grp;
  logic [1:0]      grp_q;
  logic [GW-1:0]   mix_d;
  logic [GW-1:0]   mix_q;
  logic            wr_q;

  function automatic logic [7:0] xt(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(
    input logic [31:0] c,
    input logic        inv
  );
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  m3 [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      m3[i] = x2[i] ^ a[i];
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    if (inv) begin
      r = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
           m9[0] ^ me[1] ^ mb[2] ^ md[3],
           md[0] ^ m9[1] ^ me[2] ^ mb[3],
           mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end else begin
      r = {x2[0] ^ m3[1] ^ a[2]  ^ a[3],
           a[0]  ^ x2[1] ^ m3[2] ^ a[3],
           a[0]  ^ a[1]  ^ x2[2] ^ m3[3],
           m3[0] ^ a[1]  ^ a[2]  ^ x2[3]};
    end
    return r;
  endfunction

  // k runs 0..N: N mixing cycles, then one drain cycle for the last write
  assign grp = (k_q < 3'(N)) ? k_q[1:0] : 2'd0;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (k_q == 3'(N)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mix the current column group from the latched input
  always_comb begin
    mix_d = '0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      mix_d[GW-1-32*j -: 32] = mix_col(
        in_q[127-32*(int'(grp)*COLS_PER_CYCLE+j) -: 32],
        inv_q);
    end
  end

  // merge the registered mixer group into its output columns
  always_comb begin
    out_d = out_q;
    if (wr_q) begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
        out_d[127-32*(int'(grp_q)*COLS_PER_CYCLE+j) -: 32] =
          mix_q[GW-1-32*j -: 32];
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // datapath: latch input, step column counter, stage and write results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q  <= '0;
      inv_q <= 1'b0;
      out_q <= '0;
      k_q   <= '0;
      mix_q <= '0;
      grp_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      wr_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_q  <= in_data;
            inv_q <= in_inv;
            k_q   <= '0;
          end
        end
        BUSY: begin
          if (k_q != 3'(N)) begin
            mix_q <= mix_d;
            grp_q <= grp;
            wr_q  <= 1'b1;
            k_q   <= k_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_pipe.sv
// Scoreboard bench for mix_columns_pipe.
// Runs COLS_PER_CYCLE = 1, 2 and 4 side by side on shared stimulus.
module tb_mix_columns_pipe;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_data = '0;
  logic         ir [3];
  logic         ov [3];
  logic [127:0] od [3];
  logic [127:0] sb [3][$];
  int           cyc = 0;
  int           npass = 0;
  int           ntot = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h want=%h", tag, got, exp);
  endtask

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p = '0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_state(
    input logic [127:0] s,
    input logic         inv
  );
    logic [7:0]   base [4];
    logic [7:0]   r;
    logic [31:0]  c;
    logic [127:0] o = '0;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int col = 0; col < 4; col++) begin
      c = s[127-32*col -: 32];
      for (int row = 0; row < 4; row++) begin
        r = '0;
        for (int j = 0; j < 4; j++)
          r = r ^ gmul(base[(j-row+4)%4], c[31-8*j -: 8]);
        o[127-32*col-8*row -: 8] = r;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int C   = (g == 0) ? 1 : (g == 1) ? 2 : 4;
      localparam int LAT = 4 / C + 1;
      int   acc = 0;
      logic ovp = 1'b0;

      mix_columns_pipe #(.COLS_PER_CYCLE(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (ir[g]),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (ov[g]),
        .out_ready (out_ready),
        .out_data  (od[g])
      );

      always @(negedge clk) begin
        if (!rst_n) begin
          ovp = 1'b0;
        end else begin
          if (in_valid && ir[g]) acc = cyc + 1;
          if (ov[g] && !ovp)
            check($sformatf("latency_c%0d", C),
                  128'(cyc - acc), 128'(LAT));
          ovp = ov[g];
          if (ov[g] && out_ready) begin
            if (sb[g].size() == 0)
              check($sformatf("spurious_c%0d", C),
                    128'(sb[g].size()), 128'd1);
            else
              check($sformatf("data_c%0d", C),
                    od[g], sb[g].pop_front());
          end
        end
      end
    end
  endgenerate

  task automatic send(
    input logic [127:0] d,
    input logic         inv,
    input logic [127:0] exp,
    input logic         push
  );
    int n = 0;
    @(posedge clk); #1;
    while (!(ir[0] && ir[1] && ir[2]) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", {127'd0, ir[0] & ir[1] & ir[2]}, 128'd1);
    in_data  = d;
    in_inv   = inv;
    in_valid = 1'b1;
    if (push) for (int g = 0; g < 3; g++) sb[g].push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = rnd128();
    in_inv   = ~inv;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0
           && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain",
          128'(sb[0].size() + sb[1].size() + sb[2].size()), 128'd0);
  endtask

  logic [127:0] fips_in  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  logic [127:0] fips_out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  logic [127:0] v;
  logic [127:0] snap [3];
  logic         vi;

  initial begin
    in_valid = 1'b1;
    in_data  = rnd128();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_valid", {127'd0, ov[g]}, 128'd0);
      check("rst_data", od[g], 128'd0);
    end
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      check("rst_ready", {127'd0, ir[g]}, 128'd1);

    send(fips_in, 1'b0, fips_out, 1'b1);
    drain();
    send(fips_out, 1'b1, fips_in, 1'b1);
    drain();
    send({32'hd5d5d7d6, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'hd5d5d7d6},
         1'b1,
         {32'hd4d4d4d5, 32'h2d26314c, 32'h2d26314c, 32'hd4d4d4d5},
         1'b1);
    drain();

    for (int i = 0; i < 6; i++) begin
      v  = rnd128();
      vi = 1'($urandom_range(0, 1));
      send(v, vi, ref_state(v, vi), 1'b1);
      drain();
    end

    out_ready = 1'b0;
    v = rnd128();
    send(v, 1'b0, ref_state(v, 1'b0), 1'b1);
    for (int n = 0; n < 20 && !(ov[0] && ov[1] && ov[2]); n++)
      @(negedge clk);
    check("bp_done", {127'd0, ov[0] & ov[1] & ov[2]}, 128'd1);
    for (int g = 0; g < 3; g++) snap[g] = od[g];
    repeat (10) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rnd128();
      in_inv   = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        check("bp_hold", od[g], snap[g]);
        check("bp_ready", {127'd0, ir[g]}, 128'd0);
      end
    end
    @(posedge clk); #1;
    v         = rnd128();
    in_data   = v;
    in_inv    = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int g = 0; g < 3; g++) sb[g].push_back(ref_state(v, 1'b1));
    @(posedge clk); #1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rel_valid", {127'd0, ov[g]}, 128'd0);
      check("rel_ready", {127'd0, ir[g]}, 128'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = rnd128();
    drain();

    send(rnd128(), 1'b0, 128'd0, 1'b0);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("abort_valid", {127'd0, ov[g]}, 128'd0);
      check("abort_data", od[g], 128'd0);
    end
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      check("abort_ready", {127'd0, ir[g]}, 128'd1);
    send(fips_in, 1'b0, fips_out, 1'b1);
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
